// File: rtl/mux4_sel_pkg.sv
// Shared definitions for the mux4 select controller: FSM encodings and
// default timing parameters.
package mux4_sel_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t HOLD    = 2'd1;
  localparam state_t RELEASE = 2'd2;

  localparam int MIN_HOLD_DEF = 2;
  localparam int MAX_HOLD_DEF = 15;
  localparam int CNT_W_DEF    = 4;

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: returns the first set request bit found when
// searching upward from last+1, wrapping 3->0.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       any
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    idx = last;
    any = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!any && req[last + 2'(i)]) begin
        idx = last + 2'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_sel_ctrl.sv
// Select controller for a downstream mux4: round-robin grants held for a
// bounded number of cycles, with a one-cycle gap between grants.
module mux4_sel_ctrl
  import mux4_sel_pkg::*;
#(
  parameter int MIN_HOLD = MIN_HOLD_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] control,
  output logic       valid,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'((MIN_HOLD > 0) ? MIN_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       last;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick_idx;
  logic             pick_any;

  logic hit_max;
  logic done_ok;
  logic withdraw;
  logic release_now;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign hit_max     = (cnt == MAX_CNT);
  assign done_ok     = done && (cnt >= MIN_CNT);
  assign withdraw    = !req[control];
  // All release causes collapse into one exit; done before MIN_CNT is simply dropped.
  assign release_now = hit_max || done_ok || withdraw;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      control <= 2'd0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      last    <= 2'd3;
    end else begin
      timeout <= 1'b0;
      case (state)
        HOLD: begin
          if (release_now) begin
            state   <= RELEASE;
            valid   <= 1'b0;
            last    <= control;
            cnt     <= '0;
            timeout <= hit_max;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          // IDLE and RELEASE arbitrate identically; control only moves here.
          if (pick_any) begin
            state   <= HOLD;
            control <= pick_idx;
            valid   <= 1'b1;
            cnt     <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mux4_sel_ctrl.md
MUX4_SEL_CTRL -- requirements
Module: mux4_sel_ctrl

Interface
REQ-001 The block SHALL have parameter MIN_HOLD, default 2: the minimum number of HOLD cycles before `done` is honoured.
REQ-002 The block SHALL have parameter MAX_HOLD, default 15: the HOLD cycle count at which the grant is forcibly released.
REQ-003 The block SHALL have parameter CNT_W, default 4: the width of the hold counter, with 2^CNT_W > MAX_HOLD.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req, input, 4 bits: per-source requests for sources A, B, C, D at bits 0-3.
REQ-007 The block SHALL have port done, input, 1 bit: the consumer has finished with the current selection.
REQ-008 The block SHALL have port control, output, 2 bits: the select index driving the downstream mux4 control input.
REQ-009 The block SHALL have port valid, output, 1 bit: control is stable and granted.
REQ-010 The block SHALL have port timeout, output, 1 bit: a one-cycle pulse on forced release.

Function
REQ-011 The FSM SHALL have exactly three states:
- IDLE
- HOLD
- RELEASE
REQ-012 In IDLE and RELEASE, valid SHALL be 0 and control SHALL hold its last value.
REQ-013 Arbitration SHALL be round-robin: search from (last+1) mod 4 upward with wrap to 3->0, and pick the first set req bit.
REQ-014 From IDLE or RELEASE with req != 0, the FSM SHALL load control with the picked index and enter HOLD; with req == 0, it SHALL enter or stay in IDLE.
REQ-015 Latency SHALL be one cycle: req sampled at edge n gives valid=1 after edge n+1 is not permitted; valid=1 SHALL be visible immediately after edge n.
REQ-016 The hold counter SHALL be 0 on the first HOLD cycle and increment by 1 per HOLD cycle, never exceeding MAX_HOLD-1.
REQ-017 HOLD SHALL exit to RELEASE when any of the following holds:
- done=1 and cnt >= MIN_HOLD-1;
- cnt == MAX_HOLD-1;
- req[control] == 0 (withdrawal).
REQ-018 done asserted while cnt < MIN_HOLD-1 SHALL be ignored and not remembered.
REQ-019 timeout SHALL pulse high for exactly the one cycle following the HOLD cycle in which cnt == MAX_HOLD-1, including when done or withdrawal coincides.
REQ-020 Simultaneous release causes SHALL produce a single release.
REQ-021 On entering RELEASE, the last pointer SHALL be set to control.
REQ-022 Every grant SHALL be separated by at least one cycle with valid=0, so that control never changes while valid=1.
REQ-023 control SHALL change only on the transition into HOLD.
REQ-024 A req change during HOLD other than on bit control SHALL have no effect until the next arbitration.

Reset
REQ-025 Assertion of reset_n=0 SHALL immediately set state to IDLE, control=0, valid=0, timeout=0, cnt=0 and last=3, independent of clk.
REQ-026 Reset asserted mid-HOLD SHALL abort the grant with no timeout pulse.
REQ-027 After release of reset, the first grant SHALL go to the lowest-numbered asserted req.
REQ-028 Deassertion of reset_n SHALL take effect at the first rising clk edge with reset_n high.

Structure
REQ-029 A shared package mux4_sel_pkg SHALL hold:
- the state encodings IDLE=2'd0, HOLD=2'd1, RELEASE=2'd2;
- the default values of MIN_HOLD, MAX_HOLD and CNT_W.
REQ-030 The rotate-priority pick SHALL be a combinational sub-module rr_pick4 with inputs req[3:0] and last[1:0] and outputs idx[1:0] and any.
REQ-031 The block SHALL instantiate rr_pick4 once.

Verification
REQ-032 Single request: req=0001 after reset, done=1 from HOLD cycle 1 -> control=0, valid=1 for 2 cycles, then valid=0.
REQ-033 Full fairness: req=1111 held, done=1 held -> grants 0,1,2,3,0, each with valid=1 for 2 cycles and separated by 1 cycle of valid=0.
REQ-034 Timeout: req=0100, done=0 -> valid=1 for 15 cycles, timeout=1 for one cycle, then control=2 is regranted after a 1-cycle gap.
REQ-035 Withdrawal: req=0010, then req[1] drops at HOLD cnt=0 -> valid=0 the next cycle and timeout stays 0.
REQ-036 Early done: done=1 only at cnt=0 with MIN_HOLD=2 -> done is ignored and the grant continues to timeout.
REQ-037 Reset mid-HOLD: reset_n=0 at cnt=5 with control=3 -> valid=0 and control=0 immediately; after reset with req=1010, the first grant is control=1.
